muldiv_r32m: RTL and testbench
==============================

MULDIV_R32M -- requirements
Module: muldiv_r32m

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width in bits (even, >=8).
REQ-002 SHALL have port: clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  request present.
REQ-005 SHALL have port: in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port: op  input  3  RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 SHALL have ports: A, B  input  DATA_W  operands (rs1, rs2).
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have port: result  output  DATA_W  registered result.
REQ-011 SHALL have port: illegal  output  1  registered flag, op not supported in this build.

Function
REQ-012 SHALL use FSM states IDLE, MUL, DIV, DONE; in_ready = 1 only in IDLE.
REQ-013 SHALL accept a request when in_valid && in_ready; SHALL latch op, A, B on that edge.
REQ-014 SHALL ignore in_valid while not in IDLE; no queueing.
REQ-015 Multiply ops SHALL go IDLE->MUL->DONE: out_valid asserted 2 cycles after acceptance.
REQ-016 MUL SHALL return low DATA_W bits of the 2*DATA_W product; MULH signed x signed, MULHSU signed A x unsigned B, MULHU unsigned x unsigned SHALL return the high DATA_W bits.
REQ-017 Divide ops SHALL use restoring radix-2 iteration, one quotient bit per cycle, DATA_W iterations; out_valid asserted DATA_W+1 cycles after acceptance.
REQ-018 Signed divide SHALL operate on magnitudes and correct signs: quotient truncates toward zero, remainder takes dividend's sign.
REQ-019 B = 0 SHALL bypass iteration (IDLE->DONE, out_valid 1 cycle after acceptance): DIV/DIVU give all-ones, REM/REMU give A.
REQ-020 Signed overflow (A = most-negative, B = -1) SHALL bypass iteration: DIV gives A, REM gives 0, 1-cycle latency.
REQ-021 In DONE, result and illegal SHALL hold stable while out_valid && !out_ready.
REQ-022 On out_valid && out_ready, SHALL return to IDLE next cycle; new request accepted no earlier than that cycle.
REQ-023 illegal SHALL be 0 for every supported op.

Reset
REQ-024 reset low SHALL immediately force state IDLE, out_valid 0, result 0, illegal 0, iteration counter 0, independent of clock.
REQ-025 Reset mid-operation SHALL abort it without any out_valid pulse; in_ready 1 on first cycle after reset release.

Configuration
REQ-026 Macro MULDIV_R32M_DIV_EN defined: divider datapath and DIV state built; REQ-017..020 apply.
REQ-027 MULDIV_R32M_DIV_EN undefined: no divider logic; op[2]=1 requests go IDLE->DONE with result 0, illegal 1, 1-cycle latency; multiply ops unaffected.

Structure
REQ-028 Package muldiv_r32m_pkg SHALL hold the op-code enum (funct3 values), FSM state enum and the DATA_W default constant.
REQ-029 Iterative divider SHALL be sub-module div_iter_r32m (start, operand magnitudes, done, quotient, remainder); instantiated only under MULDIV_R32M_DIV_EN.

Verification
REQ-030 MUL A=2,B=4 -> result 8, out_valid 2 cycles after accept; MULH A=2,B=-4 -> 0xFFFFFFFF; MULHU A=2,B=0xFFFFFFFC -> 0x00000001; MULHSU A=2,B=0xFFFFFFFC -> 0x00000001.
REQ-031 DIV A=-901,B=-78 -> 11; REM same operands -> -43 (0xFFFFFFD5); out_valid exactly 33 cycles after accept.
REQ-032 DIVU A=9,B=0 -> 0xFFFFFFFF; REMU A=9,B=0 -> 9; DIV A=0x80000000,B=-1 -> 0x80000000, REM -> 0; each 1-cycle latency.
REQ-033 MUL A=9,B=5 with out_ready low 3 cycles -> result 45 stable, out_valid held, in_valid pulses ignored, in_ready 0 until cycle after handshake.
REQ-034 Start DIVU A=100,B=7, drop reset at iteration 10 -> out_valid never asserts; after release in_ready 1, next DIVU 100/7 -> 14.
REQ-035 Build without MULDIV_R32M_DIV_EN: DIV A=9,B=3 -> result 0, illegal 1, 1-cycle latency; MUL 9x3 -> 27, illegal 0.

Source files
------------

// File: rtl/muldiv_r32m_pkg.sv
// Shared types and constants for the muldiv_r32m RV32M multiply/divide unit.
// The op-code enum mirrors the RV32M funct3 encoding.
package muldiv_r32m_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_e;

endpackage

// File: rtl/div_iter_r32m.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
// The first iteration is folded into the start edge so done rises DATA_W-1 cycles later.
module div_iter_r32m
    import muldiv_r32m_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]  cnt;
    logic              busy;
    logic [DATA_W-1:0] dvsr, d_in, rem_in, quo_in, rem_nx, quo_nx;
    logic [DATA_W:0]   shifted, trial;

    // One restoring step; on start it works straight from the new operands.
    always_comb begin
        rem_in  = start ? '0 : remainder;
        quo_in  = start ? dividend : quotient;
        d_in    = start ? divisor : dvsr;
        shifted = {rem_in, quo_in[DATA_W-1]};
        trial   = shifted - {1'b0, d_in};
        if (!trial[DATA_W]) begin
            rem_nx = trial[DATA_W-1:0];
            quo_nx = {quo_in[DATA_W-2:0], 1'b1};
        end else begin
            rem_nx = shifted[DATA_W-1:0];
            quo_nx = {quo_in[DATA_W-2:0], 1'b0};
        end
    end

    assign done = busy && (cnt == '0);

    // NOTE: the datapath registers are reset too, so the counter and outputs
    // are defined immediately on reset rather than after the next start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            busy      <= 1'b0;
            dvsr      <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            cnt       <= CNT_W'(DATA_W - 1);
            busy      <= 1'b1;
            dvsr      <= divisor;
            quotient  <= quo_nx;
            remainder <= rem_nx;
        end else if (busy) begin
            if (cnt != '0) begin
                cnt       <= cnt - 1'b1;
                quotient  <= quo_nx;
                remainder <= rem_nx;
            end else begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/muldiv_r32m.sv
// RV32M multiply/divide unit: 2-cycle multiply, iterative divide with valid/ready handshakes.
// Define MULDIV_R32M_DIV_EN to build the divider; otherwise divide ops are flagged illegal.
module muldiv_r32m
    import muldiv_r32m_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              illegal
);
    state_e              state;
    op_e                 op_q;
    logic [DATA_W-1:0]   a_q, b_q, mul_res;
    logic [2*DATA_W-1:0] a_ext, b_ext, prod;

    assign in_ready = (state == IDLE);

    // Sign-extending to 2*DATA_W lets one unsigned multiplier serve all four ops.
    always_comb begin
        a_ext = {{DATA_W{a_q[DATA_W-1] & (op_q == OP_MULH || op_q == OP_MULHSU)}}, a_q};
        b_ext = {{DATA_W{b_q[DATA_W-1] & (op_q == OP_MULH)}}, b_q};
        prod  = a_ext * b_ext;
        case (op_q)
            OP_MULH, OP_MULHSU, OP_MULHU: mul_res = prod[2*DATA_W-1:DATA_W];
            default:                      mul_res = prod[DATA_W-1:0];
        endcase
    end

`ifdef MULDIV_R32M_DIV_EN
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic              div_signed, b_zero, ovf, div_start, div_done;
    logic              neg_q, neg_r;
    logic [DATA_W-1:0] a_mag, b_mag, quo, rem, quo_fix, rem_fix;

    always_comb begin
        div_signed = ~op[0];
        b_zero     = (B == '0);
        ovf        = div_signed && (A == MOST_NEG) && (B == '1);
        a_mag      = (div_signed && A[DATA_W-1]) ? -A : A;
        b_mag      = (div_signed && B[DATA_W-1]) ? -B : B;
        div_start  = in_ready && in_valid && op[2] && !b_zero && !ovf;
        quo_fix    = neg_q ? -quo : quo;
        rem_fix    = neg_r ? -rem : rem;
    end

    div_iter_r32m #(.DATA_W(DATA_W)) u_div (
        .clock     (clock),
        .reset     (reset),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );
`endif

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            illegal   <= 1'b0;
            op_q      <= OP_MUL;
            a_q       <= '0;
            b_q       <= '0;
`ifdef MULDIV_R32M_DIV_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q <= op_e'(op);
                    a_q  <= A;
                    b_q  <= B;
                    if (!op[2]) begin
                        state <= MUL;
`ifdef MULDIV_R32M_DIV_EN
                    end else if (b_zero) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        illegal   <= 1'b0;
                        result    <= op[1] ? A : '1;
                    end else if (ovf) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        illegal   <= 1'b0;
                        result    <= op[1] ? '0 : A;
                    end else begin
                        state <= DIV;
                        neg_q <= div_signed && (A[DATA_W-1] ^ B[DATA_W-1]);
                        neg_r <= div_signed && A[DATA_W-1];
`else
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        illegal   <= 1'b1;
                        result    <= '0;
`endif
                    end
                end
                MUL: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    illegal   <= 1'b0;
                    result    <= mul_res;
                end
`ifdef MULDIV_R32M_DIV_EN
                DIV: if (div_done) begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    illegal   <= 1'b0;
                    result    <= op_q[1] ? rem_fix : quo_fix;
                end
`endif
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_r32m.sv
// Scoreboard bench for muldiv_r32m: expectations are queued at acceptance and
// compared when out_valid appears; follows MULDIV_R32M_DIV_EN like the design.
module tb_muldiv_r32m;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        illegal;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    muldiv_r32m #(.DATA_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t           e;
        longint         sa, sb_l, ub, ps;
        longint unsigned pu;
        int             sa32, sb32;
        sa   = longint'($signed(a));
        sb_l = longint'($signed(b));
        ub   = longint'({32'b0, b});
        sa32 = $signed(a);
        sb32 = $signed(b);
        e.ill = 1'b0;
        e.lat = 2;
        e.res = '0;
        ps = 0;
        pu = 0;
        case (o)
            3'b000: e.res = a * b;
            3'b001: begin ps = sa * sb_l; e.res = ps[63:32]; end
            3'b010: begin ps = sa * ub;   e.res = ps[63:32]; end
            3'b011: begin pu = {32'b0, a} * {32'b0, b}; e.res = pu[63:32]; end
            default: begin
`ifdef MULDIV_R32M_DIV_EN
                e.lat = 33;
                if (b == 32'h0) begin
                    e.lat = 1;
                    e.res = o[1] ? a : 32'hFFFF_FFFF;
                end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lat = 1;
                    e.res = o[1] ? 32'h0 : a;
                end else begin
                    case (o)
                        3'b100:  e.res = sa32 / sb32;
                        3'b101:  e.res = a / b;
                        3'b110:  e.res = sa32 % sb32;
                        default: e.res = a % b;
                    endcase
                end
`else
                e.lat = 1;
                e.ill = 1'b1;
                e.res = '0;
`endif
            end
        endcase
        return e;
    endfunction

    // Issue one request, queue its expectation, then wait for and score the response.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        exp_t        e;
        int          lat;
        logic [31:0] held;
        @(negedge clock);
        in_valid = 1'b1;
        op = o;
        A = a;
        B = b;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clock);
        sb.push_back(ref_model(o, a, b));
        @(negedge clock);
        in_valid = 1'b0;
        out_ready = (stall == 0);
        lat = 1;
        while (!out_valid && lat < 100) begin
            check({tag, ".busy_ready"}, 32'(in_ready), 32'd0);
            @(negedge clock);
            lat++;
        end
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, ".latency"}, 32'(lat), 32'(e.lat));
            check({tag, ".result"}, result, e.res);
            check({tag, ".illegal"}, 32'(illegal), 32'(e.ill));
        end
        held = result;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            op = 3'b011;
            A = 32'h1234_5678;
            B = 32'h0000_0003;
            @(negedge clock);
            check({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".stall_result"}, result, held);
            check({tag, ".stall_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check({tag, ".post_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int          seen;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        #12;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.result", result, 32'd0);
        check("reset.illegal", 32'(illegal), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        reset = 1'b1;

        run_op("mul_2x4", 3'b000, 32'd2, 32'd4, 0);
        run_op("mulh_2xm4", 3'b001, 32'd2, 32'hFFFF_FFFC, 0);
        run_op("mulhu", 3'b011, 32'd2, 32'hFFFF_FFFC, 0);
        run_op("mulhsu", 3'b010, 32'd2, 32'hFFFF_FFFC, 0);
        run_op("mulhsu_neg", 3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 0);
        run_op("div_m901", 3'b100, 32'hFFFF_FC7B, 32'hFFFF_FFB2, 0);
        run_op("rem_m901", 3'b110, 32'hFFFF_FC7B, 32'hFFFF_FFB2, 0);
        run_op("divu_by0", 3'b101, 32'd9, 32'd0, 0);
        run_op("remu_by0", 3'b111, 32'd9, 32'd0, 0);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("mul_stall", 3'b000, 32'd9, 32'd5, 3);
        run_op("div_9_3", 3'b100, 32'd9, 32'd3, 0);
        run_op("mul_9_3", 3'b000, 32'd9, 32'd3, 0);

        // Reset in the middle of an operation must abort it silently.
        @(negedge clock);
        in_valid = 1'b1;
`ifdef MULDIV_R32M_DIV_EN
        op = 3'b101;
`else
        op = 3'b000;
`endif
        A = 32'd100;
        B = 32'd7;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
`ifdef MULDIV_R32M_DIV_EN
        repeat (9) @(negedge clock);
`endif
        #2 reset = 1'b0;
        #1;
        check("abort.in_ready_async", 32'(in_ready), 32'd1);
        check("abort.out_valid_async", 32'(out_valid), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort.in_ready_release", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(negedge clock);
        end
        check("abort.no_out_valid", 32'(seen), 32'd0);
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 0);

        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op($sformatf("rand%0d", i), ro, ra, rb, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
